// File: rtl/isp_remosaic_m_pkg.sv
// Shared ISP constants: CFA phase codes, Bayer
// phase encodings and the unity channel gain.
package isp_remosaic_m_pkg;

  localparam logic [1:0] FMT_R  = 2'd0;
  localparam logic [1:0] FMT_Gr = 2'd1;
  localparam logic [1:0] FMT_Gb = 2'd2;
  localparam logic [1:0] FMT_B  = 2'd3;

  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_t;

  localparam logic [11:0] GAIN_UNITY = 12'h100;

  function automatic logic [1:0] cfa_phase(
    input logic [1:0] bayer,
    input logic       odd_line,
    input logic       odd_pix
  );
    return bayer ^ {odd_line, odd_pix};
  endfunction

endpackage

// File: rtl/isp_remosaic_m_gain_sat.sv
// Gain stage: registered full-width product, then round (+0x80, >>8)
// and saturate. Ports: i_clk, i_rst, i_vld, i_pix, i_gain -> o_pix.
module isp_gain_sat #(
  parameter int BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_vld,
  input  logic [BITS-1:0] i_pix,
  input  logic [11:0]     i_gain,
  output logic [BITS-1:0] o_pix
);

  localparam int PW = BITS + 12;

  logic          r_vld;
  logic [PW-1:0] r_prod;
  logic [BITS+3:0] w_shr;
  logic [BITS-1:0] w_sat;

  // Product cannot overflow PW bits even after adding the round constant.
  assign w_shr = (BITS+4)'((r_prod + PW'(128)) >> 8);
  assign w_sat = (|w_shr[BITS+3:BITS]) ? '1 : w_shr[BITS-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld  <= 1'b0;
      r_prod <= '0;
      o_pix  <= '0;
    end else begin
      r_vld  <= i_vld;
      r_prod <= PW'(i_pix) * PW'(i_gain);
      o_pix  <= r_vld ? w_sat : '0;
    end
  end

endmodule

// File: rtl/isp_remosaic_m.sv
// RGB to Bayer remosaic with per-channel gain, 3-cycle latency.
// Ports: pclk, rst, in_* syncs/RGB, gain_r/g/b -> out_* syncs, out_raw, line_len_err.
module isp_remosaic_m
  import isp_remosaic_m_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int BAYER  = 0
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic            in_de,
  input  logic [BITS-1:0] in_r,
  input  logic [BITS-1:0] in_g,
  input  logic [BITS-1:0] in_b,
  input  logic [11:0]     gain_r,
  input  logic [11:0]     gain_g,
  input  logic [11:0]     gain_b,
  output logic            out_href,
  output logic            out_vsync,
  output logic            out_de,
  output logic [BITS-1:0] out_raw,
  output logic            line_len_err
);

  localparam logic [1:0] P_BAYER = 2'(BAYER);

  logic        r_armed;
  logic        r_href_d;
  logic        r_vs_d;
  logic        r_odd_pix;
  logic        r_odd_line;
  logic [15:0] r_cnt;
  logic [11:0] r_gain_r;
  logic [11:0] r_gain_g;
  logic [11:0] r_gain_b;
  logic [2:0]  r_href_sr;
  logic [2:0]  r_vs_sr;
  logic [2:0]  r_de_sr;
  logic        r_s1_vld;
  logic [BITS-1:0] r_s1_pix;
  logic [11:0] r_s1_gain;

  logic        w_href;
  logic        w_fall;
  logic        w_vs_rise;
  logic [1:0]  w_fmt;
  logic [BITS-1:0] w_pix;
  logic [11:0] w_gain;
  logic        w_unused_height;

  assign w_unused_height = (HEIGHT == 0);

  // After reset, a line already in progress is ignored until
  // in_href has been seen low, so output restarts on a fresh line.
  assign w_href    = in_href & r_armed;
  assign w_fall    = r_href_d & ~w_href;
  assign w_vs_rise = in_vsync & ~r_vs_d;
  assign w_fmt     = cfa_phase(P_BAYER, r_odd_line, r_odd_pix);

  always_comb begin
    w_pix  = in_g;
    w_gain = r_gain_g;
    unique case (w_fmt)
      FMT_R: begin
        w_pix  = in_r;
        w_gain = r_gain_r;
      end
      FMT_Gr, FMT_Gb: begin
        w_pix  = in_g;
        w_gain = r_gain_g;
      end
      FMT_B: begin
        w_pix  = in_b;
        w_gain = r_gain_b;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_armed    <= 1'b0;
      r_href_d   <= 1'b0;
      r_vs_d     <= 1'b0;
      r_odd_pix  <= 1'b0;
      r_odd_line <= 1'b0;
      r_cnt      <= '0;
      line_len_err <= 1'b0;
      r_gain_r   <= GAIN_UNITY;
      r_gain_g   <= GAIN_UNITY;
      r_gain_b   <= GAIN_UNITY;
    end else begin
      r_armed   <= r_armed | ~in_href;
      r_href_d  <= w_href;
      r_vs_d    <= in_vsync;
      r_odd_pix <= w_href & ~r_odd_pix;
      if (in_vsync)
        r_odd_line <= 1'b0;
      else if (w_fall)
        r_odd_line <= ~r_odd_line;
      if (!w_href)
        r_cnt <= '0;
      else if (r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
      if (w_vs_rise)
        line_len_err <= 1'b0;
      else if (w_fall && (r_cnt != 16'(WIDTH)))
        line_len_err <= 1'b1;
      if (w_vs_rise) begin
        r_gain_r <= gain_r;
        r_gain_g <= gain_g;
        r_gain_b <= gain_b;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_href_sr <= '0;
      r_vs_sr   <= '0;
      r_de_sr   <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_pix  <= '0;
      r_s1_gain <= '0;
    end else begin
      r_href_sr <= {r_href_sr[1:0], w_href};
      r_vs_sr   <= {r_vs_sr[1:0], in_vsync};
      r_de_sr   <= {r_de_sr[1:0], in_de};
      r_s1_vld  <= w_href;
      r_s1_pix  <= w_pix;
      r_s1_gain <= w_gain;
    end
  end

  assign out_href  = r_href_sr[2];
  assign out_vsync = r_vs_sr[2];
  assign out_de    = r_de_sr[2];

  isp_gain_sat #(
    .BITS(BITS)
  ) u_gain_sat (
    .i_clk  (pclk),
    .i_rst  (rst),
    .i_vld  (r_s1_vld),
    .i_pix  (r_s1_pix),
    .i_gain (r_s1_gain),
    .o_pix  (out_raw)
  );

endmodule

// File: doc/isp_remosaic_m.md
ISP_REMOSAIC_M -- requirements
Module: isp_remosaic_m

Interface
REQ-001 Parameter BITS, default 8: pixel component width.
REQ-002 Parameter WIDTH, default 1280: expected active pixels per line.
REQ-003 Parameter HEIGHT, default 960: nominal lines per frame; informational only.
REQ-004 Parameter BAYER, default 0: CFA phase of pixel (0,0); 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
REQ-005 pclk  input  1  pixel clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_href, in_vsync, in_de  input  1 each  input line-valid, frame sync (active-high), data-enable.
REQ-008 in_r, in_g, in_b  input  BITS each  RGB pixel, valid while in_href high.
REQ-009 gain_r, gain_g, gain_b  input  12 each  unsigned Q4.8 channel gain; 0x100 = 1.0.
REQ-010 out_href, out_vsync, out_de  output  1 each  input syncs delayed by the pipeline latency.
REQ-011 out_raw  output  BITS  Bayer mosaic sample.
REQ-012 line_len_err  output  1  sticky flag: a line in the current frame had a length other than WIDTH.

Function
REQ-013 odd_pix SHALL clear on any cycle with in_href low and toggle on each cycle with in_href high; the first pixel of every line has odd_pix=0.
REQ-014 odd_line SHALL clear while in_vsync is high and toggle on each in_href falling edge (previous in_href=1, current 0).
REQ-015 Phase fmt = BAYER[1:0] XOR {odd_line, odd_pix}: 0 R, 1 Gr, 2 Gb, 3 B.
REQ-016 Stage 1 SHALL register the component selected by fmt (R: in_r, Gr/Gb: in_g, B: in_b) and the matching active gain.
REQ-017 Stage 2 SHALL register the full-width product pixel*gain, (BITS+12) bits, with no truncation.
REQ-018 Stage 3 SHALL compute (product + 0x80) >> 8 and saturate to 2^BITS-1 if the result exceeds BITS bits.
REQ-019 Latency: data and out_href/out_vsync/out_de SHALL be delayed by exactly 3 pclk cycles; the syncs SHALL use a 3-deep shift register.
REQ-020 out_raw SHALL be 0 whenever out_href is low.
REQ-021 Active gains SHALL load from gain_r/g/b only on an in_vsync rising edge; gain changes mid-frame SHALL have no effect until the next frame.
REQ-022 A 16-bit pixel counter SHALL clear when in_href is low, increment on each in_href-high cycle, and saturate at 0xFFFF.
REQ-023 On an in_href falling edge, line_len_err SHALL set if the counter differs from WIDTH.
REQ-024 line_len_err SHALL clear on an in_vsync rising edge; clear SHALL win when both events occur in the same cycle.
REQ-025 in_de SHALL only be delayed; it does not qualify data or counters.

Reset
REQ-026 While rst is high at a pclk edge: all outputs, pipeline registers, sync delay bits, odd_pix, odd_line, counter and line_len_err SHALL be 0; active gains SHALL be 0x100.
REQ-027 Reset asserted mid-line SHALL discard in-flight pixels; the first output after release SHALL come from a new in_href rising edge.

Structure
REQ-028 The shared ISP package SHALL hold the CFA phase constants (FMT_R=0, FMT_Gr=1, FMT_Gb=2, FMT_B=3), the BAYER encodings and the unity gain constant 0x100.
REQ-029 One sub-module, isp_gain_sat (multiply, round, saturate, two registered stages), SHALL implement stages 2-3.

Verification
REQ-030 Directed test 1: BAYER=0, unity gains, r=10, g=20, b=30, 4x4 frame -> line 0 out_raw 10,20,10,20; line 1 out_raw 20,30,20,30; syncs delayed by 3 cycles.
REQ-031 Directed test 2: BAYER=3, same stimulus -> line 0 out_raw 30,20,30,20; line 1 out_raw 20,10,20,10.
REQ-032 Directed test 3: gain_r=0x180, r=100 -> R sites output 150; gain_r=0x400, r=200 -> R sites output 255 (saturated).
REQ-033 Directed test 4: change gain_g from 0x100 to 0x200 mid-frame, g=50 -> G output stays 50 until after the next in_vsync rising edge, then 100.
REQ-034 Directed test 5: WIDTH=4, one line of 5 pixels -> line_len_err=1 the cycle after the in_href falling edge; it stays 1 until the next in_vsync rising edge, then 0.
REQ-035 Directed test 6: assert rst for 1 cycle mid-line -> all outputs 0 on the next cycle, gains 0x100, and the next line restarts at phase fmt=BAYER.
